w5300_ready_gate: RTL and testbench

Sits directly downstream of the W5300 reset pulse generator. It watches the `w5300_resetl` line, holds off all QL host accesses to the W5300 while the chip is in reset, and keeps holding them off for a programmable settle time after release. The settle time covers the W5300 PLL lock time. It drives the W5300 chip select, exports a ready status bit for the host-visible status register, and flags (sticky) any access the host attempts before the chip is ready.

---
 rtl/w5300_ready_gate.sv | 135 +++++++++++++
 tb/tb_w5300_ready_gate.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/w5300_ready_gate.sv
// Purpose: gate host accesses to the W5300 until its reset is released and the PLL has settled.
// Latency: 2-cycle reset-line sync, then PRESCALE*SETTLE_TICKS cycles of settle before ready.
// Backpressure: host_hold asserts (DTACK withheld) for any host_cs while not ready; csl held high.
module w5300_ready_gate #(
  parameter int PRESCALE     = 256,
  parameter int SETTLE_TICKS = 300,
  parameter int PRE_W        = 8,
  parameter int TICK_W       = 16
) (
  input  logic clk,
  input  logic resetl,
  input  logic w5300_resetl,
  input  logic host_cs,
  input  logic err_clr,
  output logic w5300_csl,
  output logic w5300_ready,
  output logic host_hold,
  output logic access_err
);

  typedef enum logic [1:0] {
    IN_RESET = 2'd0,
    SETTLE   = 2'd1,
    READY    = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SETTLE_TICKS - 1);

  logic              rs1;
  logic              rs2;
  state_t            state;
  state_t            state_nxt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [PRE_W-1:0]  pre_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_nxt;
  logic              pre_last;
  logic              settle_done;
  logic              ready_dec;
  logic              cs_d;
  logic              err_set;

  // Two-flop synchronizer for the chip reset line; reset treats the chip as held in reset.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      rs1 <= 1'b0;
      rs2 <= 1'b0;
    end else begin
      rs1 <= w5300_resetl;
      rs2 <= rs1;
    end
  end

  assign pre_last    = (pre_cnt == PRE_LAST);
  assign settle_done = pre_last && (tick_cnt == TICK_LAST);

  // State register.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state <= IN_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a low synchronized reset line overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (!rs2) begin
      state_nxt = IN_RESET;
    end else begin
      case (state)
        IN_RESET: state_nxt = SETTLE;
        SETTLE:   if (settle_done) state_nxt = READY;
        READY:    state_nxt = READY;
        default:  state_nxt = IN_RESET;
      endcase
    end
  end

  // Settle counters advance only while settling; everywhere else they sit at zero.
  always_comb begin
    pre_nxt  = '0;
    tick_nxt = '0;
    if (rs2 && (state == SETTLE) && !settle_done) begin
      if (pre_last) begin
        pre_nxt  = '0;
        tick_nxt = tick_cnt + 1'b1;
      end else begin
        pre_nxt  = pre_cnt + 1'b1;
        tick_nxt = tick_cnt;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      pre_cnt  <= pre_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  // Output decode from the registered state only, so no decode glitches reach the chip select.
  always_comb begin
    ready_dec = (state == READY);
  end

  assign w5300_ready = ready_dec;
  assign w5300_csl   = ~(host_cs & ready_dec);
  assign host_hold   = host_cs & ~ready_dec;

  // Only the rising edge of host_cs counts as a new access, so one in flight at reset entry is ignored.
  assign err_set = host_cs & ~cs_d & ~ready_dec;

  // Sticky access-error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      cs_d       <= 1'b0;
      access_err <= 1'b0;
    end else begin
      cs_d <= host_cs;
      if (err_set) begin
        access_err <= 1'b1;
      end else if (err_clr) begin
        access_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_w5300_ready_gate.sv
// Bench for w5300_ready_gate with PRESCALE=4, SETTLE_TICKS=3.
// Reference: ready once the reset line has been sampled high for PRESCALE*SETTLE_TICKS+1
// consecutive edges, seen two edges later; access_err from rising host_cs while not ready.
module tb_w5300_ready_gate;

  localparam int P = 4;
  localparam int T = 3;
  localparam int RUN_NEED = P * T + 1;

  logic clk;
  logic resetl;
  logic w5300_resetl;
  logic host_cs;
  logic err_clr;
  logic w5300_csl;
  logic w5300_ready;
  logic host_hold;
  logic access_err;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic ready_m;
  logic err_m;
  logic cs_prev;
  int   run_d1;
  int   run_d2;

  w5300_ready_gate #(
    .PRESCALE(P),
    .SETTLE_TICKS(T),
    .PRE_W(4),
    .TICK_W(4)
  ) dut (
    .clk(clk),
    .resetl(resetl),
    .w5300_resetl(w5300_resetl),
    .host_cs(host_cs),
    .err_clr(err_clr),
    .w5300_csl(w5300_csl),
    .w5300_ready(w5300_ready),
    .host_hold(host_hold),
    .access_err(access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ready_m = 1'b0;
    err_m   = 1'b0;
    cs_prev = 1'b0;
    run_d1  = 0;
    run_d2  = 0;
  endtask

  // One clock: drive inputs, check combinational outputs, take an edge, check registered outputs.
  task automatic step(input logic cs, input logic clr, input logic w);
    logic set;
    int   run_now;
    host_cs      = cs;
    err_clr      = clr;
    w5300_resetl = w;
    #1;
    chk("csl_comb", w5300_csl, ~(cs & ready_m));
    chk("hold_comb", host_hold, cs & ~ready_m);
    @(posedge clk);
    set = cs & ~cs_prev & ~ready_m;
    if (set) err_m = 1'b1;
    else if (clr) err_m = 1'b0;
    cs_prev = cs;
    ready_m = (run_d2 >= RUN_NEED);
    run_now = w ? ((run_d1 < 1000) ? run_d1 + 1 : run_d1) : 0;
    run_d2  = run_d1;
    run_d1  = run_now;
    #1;
    chk("ready", w5300_ready, ready_m);
    chk("access_err", access_err, err_m);
  endtask

  // Steps with the reset line high until ready is seen; returns edges taken (bounded).
  task automatic wait_ready(input string tag, input logic cs, input int exp_edges);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(cs, 1'b0, 1'b1);
      n++;
      if (w5300_ready === 1'b1) seen = 1'b1;
    end
    chk_int(tag, n, exp_edges);
  endtask

  initial begin
    int fall_at;
    int len;
    logic cs_r;
    logic w_r;
    resetl       = 1'b0;
    w5300_resetl = 1'b1;
    host_cs      = 1'b0;
    err_clr      = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", w5300_ready, 1'b0);
    chk("rst_csl", w5300_csl, 1'b1);
    chk("rst_hold", host_hold, 1'b0);
    chk("rst_err", access_err, 1'b0);
    resetl = 1'b1;

    // Power-up with host_cs asserted: ready on edge E14 (15th edge counting E0), csl high until then.
    wait_ready("powerup_edges", 1'b1, 15);
    // Host drops and clears the error raised during settle.
    step(1'b0, 1'b1, 1'b1);
    chk("err_cleared", access_err, 1'b0);

    // Normal access while ready.
    repeat (4) begin
      step(1'b1, 1'b0, 1'b1);
      chk("ready_csl_low", w5300_csl, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("ready_no_err", access_err, 1'b0);

    // Access in flight into chip reset: must not raise the error.
    step(1'b1, 1'b0, 1'b1);
    fall_at = 0;
    for (int i = 1; i <= 176; i++) begin
      if (i == 20 || i == 21 || i == 22) step(1'b1, 1'b0, 1'b0);      // new early access
      else if (i == 30) step(1'b0, 1'b1, 1'b0);                         // clear it
      else if (i == 31) step(1'b1, 1'b1, 1'b0);                         // set/clear collision
      else step((i <= 10), 1'b0, 1'b0);
      if (fall_at == 0 && w5300_ready === 1'b0) fall_at = i;
      if (i == 10) chk("inflight_no_err", access_err, 1'b0);
      if (i == 21) chk("early_hold", host_hold, 1'b1);
      if (i == 31) chk("collision_set_wins", access_err, 1'b1);
    end
    chk_int("reset_fall_edge", fall_at, 3);
    wait_ready("rerelease_edges", 1'b0, 15);

    // Reset mid-settle: drop the line when tick=2, prescaler=1 (after E11), then full settle again.
    repeat (5) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    chk("midsettle_not_ready", w5300_ready, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    wait_ready("midsettle_edges", 1'b0, 15);

    // Randomized traffic with occasional reset-line pulses of random length.
    cs_r = 1'b0;
    w_r  = 1'b1;
    len  = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cs_r = ~cs_r;
      if (len > 0) begin
        len--;
        if (len == 0) w_r = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        w_r = 1'b0;
        len = $urandom_range(1, 20);
      end
      step(cs_r, ($urandom_range(0, 7) == 0), w_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
